// File: rtl/dig_ct_multi.sv
// dig_ct_multi: multi-channel digital input pattern matcher.
// Each input is synchronised (2 flops) and optionally debounced, then every
// output channel compares the filtered input vector against its own care
// mask / match value and drives an active-low registered output. A channel
// can be configured as sticky: once matched it stays asserted until the
// channel is rewritten through the cfg_* handshake.
// Build option: define DIG_CT_DEBOUNCE_EN to include the per-input debounce
// filter (DEB_CYC cycles); without it the filtered vector is the synchronised
// vector and DEB_CYC has no effect.
module dig_ct_multi #(
    parameter int NUM_IN  = 5,
    parameter int NUM_OUT = 3,
    parameter int DEB_CYC = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_IN-1:0]  IN,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [3:0]         cfg_sel,
    input  logic [NUM_IN-1:0]  cfg_mask,
    input  logic [NUM_IN-1:0]  cfg_val,
    input  logic               cfg_latch,
    output logic               cfg_err,
    output logic [NUM_OUT-1:0] OUT
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    // Reject parameter sets outside the supported range at elaboration.
    generate
        if (NUM_IN < 1 || NUM_IN > 32 || NUM_OUT < 1 || NUM_OUT > 16 ||
            DEB_CYC < 1 || DEB_CYC > 255) begin : g_param_check
            $error("dig_ct_multi: parameter out of legal range");
        end
    endgenerate

    logic [NUM_IN-1:0]  r_sync1;
    logic [NUM_IN-1:0]  r_sync2;
    logic [NUM_IN-1:0]  w_filt;
    logic [NUM_OUT-1:0] w_match;
    logic [NUM_OUT-1:0] w_out;

    state_t r_state;
    state_t w_state_next;
    logic   r_alive;
    logic   r_err;
    logic   w_ready;
    logic   w_accept;
    logic   w_sel_ok;

    // Two-flop synchroniser for the asynchronous inputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= IN;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DIG_CT_DEBOUNCE_EN
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYC - 1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi = gi + 1) begin : g_deb
            logic [7:0] r_cnt;
            logic       r_filt;

            // Accept a new level only after it has differed from the
            // filtered level for DEB_CYC consecutive cycles.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_cnt  <= '0;
                    r_filt <= 1'b0;
                end else if (r_sync2[gi] == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt == DEB_LAST) begin
                    r_filt <= r_sync2[gi];
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end

            assign w_filt[gi] = r_filt;
        end
    endgenerate
`else
    assign w_filt = r_sync2;
`endif

    assign w_sel_ok = ({28'd0, cfg_sel} < 32'(NUM_OUT));
    assign w_accept = cfg_valid && w_ready;

    genvar gk;
    generate
        for (gk = 0; gk < NUM_OUT; gk = gk + 1) begin : g_ch
            logic [NUM_IN-1:0] r_mask;
            logic [NUM_IN-1:0] r_val;
            logic              r_latch;
            logic              r_sticky;
            logic              r_out;
            logic              w_wr;

            assign w_wr        = w_accept && (cfg_sel == 4'(gk));
            assign w_match[gk] = (r_mask != '0) &&
                                 ((w_filt & r_mask) == (r_val & r_mask));

            // Channel pattern, sticky flag and active-low output; a new
            // match in the clearing cycle keeps the sticky flag set.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_mask   <= '0;
                    r_val    <= '0;
                    r_latch  <= 1'b0;
                    r_sticky <= 1'b0;
                    r_out    <= 1'b1;
                end else begin
                    if (w_wr) begin
                        r_mask  <= cfg_mask;
                        r_val   <= cfg_val;
                        r_latch <= cfg_latch;
                    end
                    r_sticky <= (w_wr ? 1'b0 : r_sticky) | (r_latch & w_match[gk]);
                    r_out    <= ~(w_match[gk] | r_sticky);
                end
            end

            assign w_out[gk] = r_out;
        end
    endgenerate

    assign OUT = w_out;

    // Configuration FSM state, post-reset ready enable and error pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_alive <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_alive <= 1'b1;
            r_err   <= w_accept && !w_sel_ok;
        end
    end

    // Next state: one ACK cycle after every accepted write.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = r_alive;
                if (cfg_valid && r_alive) begin
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign cfg_ready = w_ready;
    assign cfg_err   = r_err;

endmodule

// File: tb/tb_dig_ct_multi.sv
// tb_dig_ct_multi: directed bench for dig_ct_multi (NUM_IN=5, NUM_OUT=3,
// DEB_CYC=4). Expected latencies follow the DIG_CT_DEBOUNCE_EN build option.
module tb_dig_ct_multi;

    localparam int NUM_IN  = 5;
    localparam int NUM_OUT = 3;
    localparam int DEB_CYC = 4;
`ifdef DIG_CT_DEBOUNCE_EN
    localparam int LAT = 3 + DEB_CYC;
`else
    localparam int LAT = 3;
`endif

    logic               CLK;
    logic               RST_N;
    logic [NUM_IN-1:0]  IN;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [3:0]         cfg_sel;
    logic [NUM_IN-1:0]  cfg_mask;
    logic [NUM_IN-1:0]  cfg_val;
    logic               cfg_latch;
    logic               cfg_err;
    logic [NUM_OUT-1:0] OUT;

    int n_cmp = 0;
    int n_bad = 0;

    dig_ct_multi #(
        .NUM_IN (NUM_IN),
        .NUM_OUT(NUM_OUT),
        .DEB_CYC(DEB_CYC)
    ) u_dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IN       (IN),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_sel  (cfg_sel),
        .cfg_mask (cfg_mask),
        .cfg_val  (cfg_val),
        .cfg_latch(cfg_latch),
        .cfg_err  (cfg_err),
        .OUT      (OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) begin
            $display("check %-14s observed %0h expected %0h ok", tag, obs, exp);
        end else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One write: checks handshake, error pulse and OUT at the accept edge
    // and the following edge.
    task automatic cfg_write(input logic [3:0] sel, input logic [4:0] mask,
                             input logic [4:0] val, input logic latch,
                             input logic exp_err, input logic [2:0] exp_out_a,
                             input logic [2:0] exp_out_a1);
        chk("wr_ready_pre", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_mask  = mask;
        cfg_val   = val;
        cfg_latch = latch;
        step(1);
        cfg_valid = 1'b0;
        chk("wr_ready_ack", 32'(cfg_ready), 32'd0);
        chk("wr_err_ack",   32'(cfg_err),   32'(exp_err));
        chk("wr_out_a",     32'(OUT),       32'(exp_out_a));
        step(1);
        chk("wr_ready_idle", 32'(cfg_ready), 32'd1);
        chk("wr_err_idle",   32'(cfg_err),   32'd0);
        chk("wr_out_a1",     32'(OUT),       32'(exp_out_a1));
    endtask

    initial begin
        RST_N     = 1'b0;
        IN        = 5'b11111;
        cfg_valid = 1'b0;
        cfg_sel   = 4'd0;
        cfg_mask  = '0;
        cfg_val   = '0;
        cfg_latch = 1'b0;

        // Reset state
        step(3);
        chk("rst_out",   32'(OUT),       32'h7);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_err",   32'(cfg_err),   32'd0);
        RST_N = 1'b1;
        #1;
        chk("rel_ready0", 32'(cfg_ready), 32'd0);
        step(1);
        chk("rel_ready1", 32'(cfg_ready), 32'd1);
        IN = 5'b00000;
        step(12);
        chk("idle_out", 32'(OUT), 32'h7);

        // Match on channel 0 with exact latency
        cfg_write(4'd0, 5'b00100, 5'b00100, 1'b0, 1'b0, 3'b111, 3'b111);
        IN = 5'b00100;
        step(LAT - 1);
        chk("match_early", 32'(OUT), 32'h7);
        step(1);
        chk("match_out", 32'(OUT), 32'h6);
        IN = 5'b00000;
        step(LAT - 1);
        chk("unmatch_early", 32'(OUT), 32'h6);
        step(1);
        chk("unmatch_out", 32'(OUT), 32'h7);
        step(4);

        // Three-cycle glitch on IN[2]
        IN = 5'b00100;
        step(3);
        IN = 5'b00000;
`ifdef DIG_CT_DEBOUNCE_EN
        for (int i = 0; i < 10; i++) begin
            chk("glitch_hold", 32'(OUT), 32'h7);
            step(1);
        end
`else
        chk("glitch_pass", 32'(OUT), 32'h6);
        step(3);
        chk("glitch_end", 32'(OUT), 32'h7);
        step(4);
`endif

        // Sticky channel 2
        cfg_write(4'd2, 5'b01000, 5'b01000, 1'b1, 1'b0, 3'b111, 3'b111);
        IN = 5'b01000;
        step(6);
        IN = 5'b00000;
        step(LAT + 6);
        chk("sticky_set", 32'(OUT), 32'h3);
        step(5);
        chk("sticky_hold", 32'(OUT), 32'h3);
        cfg_write(4'd2, 5'b01000, 5'b01000, 1'b1, 1'b0, 3'b011, 3'b111);
        step(3);
        chk("sticky_clr", 32'(OUT), 32'h7);

        // Illegal channel select leaves everything unchanged
        IN = 5'b00100;
        step(LAT + 1);
        chk("pre_ill_out", 32'(OUT), 32'h6);
        cfg_write(4'd5, 5'b00100, 5'b00100, 1'b1, 1'b1, 3'b110, 3'b110);
        step(LAT + 2);
        chk("post_ill_out", 32'(OUT), 32'h6);
        IN = 5'b00000;
        step(LAT + 2);
        chk("post_ill_rel", 32'(OUT), 32'h7);

        // Reset in the middle of a debounce discards count and config
        IN = 5'b00100;
        step(3);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_out",   32'(OUT),       32'h7);
        chk("mid_rst_ready", 32'(cfg_ready), 32'd0);
        step(2);
        RST_N = 1'b1;
        step(LAT + 3);
        chk("post_rst_out",   32'(OUT),       32'h7);
        chk("post_rst_ready", 32'(cfg_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
